// File: rtl/cat_pwr_seq.sv
// Power-up / power-down sequencer for the CAT control pins: output-enable,
// timed reset pulse, settle window, then enable; a stop walks through a STOP phase.
module cat_pwr_seq #(
  parameter int T_OE     = 16,
  parameter int T_RST    = 1000,
  parameter int T_SETTLE = 5000,
  parameter int CNT_W    = 16
) (
  input  logic       bus_clk,
  input  logic       bus_rst,
  input  logic       start,
  input  logic       stop,
  input  logic       txnrx_req,
  output logic       cat_oe,
  output logic       cat_resetn,
  output logic       cat_enable,
  output logic       cat_txnrx,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OE     = 3'd1,
    S_RST    = 3'd2,
    S_SETTLE = 3'd3,
    S_RUN    = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] OE_LOAD     = CNT_W'(T_OE - 1);
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(T_SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cat_oe_q, cat_oe_d;
  logic             cat_resetn_q, cat_resetn_d;
  logic             cat_enable_q, cat_enable_d;
  logic             cat_txnrx_q, cat_txnrx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             stoppable;
  logic             cnt_zero;

  assign stoppable = (state_q == S_OE) || (state_q == S_RST) ||
                     (state_q == S_SETTLE) || (state_q == S_RUN);
  assign cnt_zero  = (cnt_q == '0);

  // Next-state: stop has priority over both timed exits and start.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (stop && stoppable) begin
      state_d = S_STOP;
      cnt_d   = OE_LOAD;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_OE;
            cnt_d   = OE_LOAD;
          end
        end
        S_OE: begin
          if (cnt_zero) begin
            state_d = S_RST;
            cnt_d   = RST_LOAD;
          end else cnt_d = cnt_q - CNT_ONE;
        end
        S_RST: begin
          if (cnt_zero) begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end else cnt_d = cnt_q - CNT_ONE;
        end
        S_SETTLE: begin
          if (cnt_zero) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else cnt_d = cnt_q - CNT_ONE;
        end
        S_STOP: begin
          if (cnt_zero) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else cnt_d = cnt_q - CNT_ONE;
        end
        S_RUN:   ;
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registers present them
  // in the cycle right after the transition edge.
  always_comb begin
    cat_oe_d     = 1'b0;
    cat_resetn_d = 1'b0;
    cat_enable_d = 1'b0;
    ready_d      = 1'b0;
    busy_d       = 1'b0;
    unique case (state_d)
      S_OE, S_RST, S_STOP: begin
        cat_oe_d = 1'b1;
        busy_d   = 1'b1;
      end
      S_SETTLE: begin
        cat_oe_d     = 1'b1;
        cat_resetn_d = 1'b1;
        busy_d       = 1'b1;
      end
      S_RUN: begin
        cat_oe_d     = 1'b1;
        cat_resetn_d = 1'b1;
        cat_enable_d = 1'b1;
        ready_d      = 1'b1;
      end
      default: ;
    endcase
    cat_txnrx_d = (state_d == S_RUN) && txnrx_req;
    done_d      = (state_d == S_RUN) && (state_q != S_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cat_oe_q     <= 1'b0;
      cat_resetn_q <= 1'b0;
      cat_enable_q <= 1'b0;
      cat_txnrx_q  <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cat_oe_q     <= cat_oe_d;
      cat_resetn_q <= cat_resetn_d;
      cat_enable_q <= cat_enable_d;
      cat_txnrx_q  <= cat_txnrx_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign cat_oe     = cat_oe_q;
  assign cat_resetn = cat_resetn_q;
  assign cat_enable = cat_enable_q;
  assign cat_txnrx  = cat_txnrx_q;
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign state      = state_q;

endmodule

// File: tb/tb_cat_pwr_seq.sv
// Directed bench for cat_pwr_seq with short phase timings (T_OE=2, T_RST=4, T_SETTLE=3).
module tb_cat_pwr_seq;

  logic       bus_clk = 1'b0;
  logic       bus_rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       txnrx_req = 1'b0;
  logic       cat_oe, cat_resetn, cat_enable, cat_txnrx, ready, busy, done;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  cat_pwr_seq #(.T_OE(2), .T_RST(4), .T_SETTLE(3), .CNT_W(8)) dut (
    .bus_clk    (bus_clk),
    .bus_rst    (bus_rst),
    .start      (start),
    .stop       (stop),
    .txnrx_req  (txnrx_req),
    .cat_oe     (cat_oe),
    .cat_resetn (cat_resetn),
    .cat_enable (cat_enable),
    .cat_txnrx  (cat_txnrx),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .state      (state)
  );

  always #5 bus_clk = ~bus_clk;

  // Packed view {oe, resetn, enable, txnrx, ready, busy, done, state[2:0]}.
  function automatic logic [9:0] vec(input logic oe, rn, en, tx, rdy, bsy, dn,
                                     input logic [2:0] st);
    return {oe, rn, en, tx, rdy, bsy, dn, st};
  endfunction

  localparam logic [9:0] V_IDLE   = 10'b0000000_000;
  localparam logic [9:0] V_OE     = 10'b1000010_001;
  localparam logic [9:0] V_RST    = 10'b1000010_010;
  localparam logic [9:0] V_SETTLE = 10'b1100010_011;
  localparam logic [9:0] V_STOP   = 10'b1000010_101;

  function automatic logic [9:0] v_run(input logic dn, input logic tx);
    return vec(1'b1, 1'b1, 1'b1, tx, 1'b1, 1'b0, dn, 3'd4);
  endfunction

  task automatic check(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = {cat_oe, cat_resetn, cat_enable, cat_txnrx, ready, busy, done, state};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  // Full bring-up from IDLE: start pulse at edge 0, RUN entered at edge 9.
  task automatic bring_up(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_e0_oe"}, V_OE);
    tick(); check({tag, "_e1_oe"}, V_OE);
    for (int i = 2; i <= 5; i++) begin
      tick(); check($sformatf("%s_e%0d_rst", tag, i), V_RST);
    end
    for (int i = 6; i <= 8; i++) begin
      tick(); check($sformatf("%s_e%0d_settle", tag, i), V_SETTLE);
    end
    tick(); check({tag, "_e9_run_done"}, v_run(1'b1, 1'b0));
    tick(); check({tag, "_e10_run"}, v_run(1'b0, 1'b0));
  endtask

  initial begin
    // Reset held with start and stop both high: nothing may move.
    start = 1'b1;
    stop  = 1'b1;
    #2;
    check("rst_async", V_IDLE);
    tick(); check("rst_held_1", V_IDLE);
    tick(); check("rst_held_2", V_IDLE);
    @(negedge bus_clk);
    start   = 1'b0;
    stop    = 1'b0;
    bus_rst = 1'b0;
    tick(); check("post_rst_idle", V_IDLE);
    tick(); check("post_rst_idle_2", V_IDLE);

    // Stop in IDLE is ignored.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_in_idle", V_IDLE);

    // Nominal bring-up.
    bring_up("nom");

    // txnrx_req 0,1,1,0 follows with one cycle of latency.
    txnrx_req = 1'b0; tick(); check("tx_0", v_run(1'b0, 1'b0));
    txnrx_req = 1'b1; tick(); check("tx_1", v_run(1'b0, 1'b1));
    txnrx_req = 1'b1; tick(); check("tx_2", v_run(1'b0, 1'b1));
    txnrx_req = 1'b0; tick(); check("tx_3", v_run(1'b0, 1'b0));

    // Stop from RUN with txnrx_req high, then start during STOP is ignored.
    txnrx_req = 1'b1;
    stop      = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_run_1", V_STOP);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("stop_run_2_start_ignored", V_STOP);
    tick(); check("stop_run_idle", V_IDLE);
    tick(); check("stop_run_idle_hold", V_IDLE);
    txnrx_req = 1'b0;

    // Abort during RST when the counter reads 2 (cycle after edge 3).
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ab_e0_oe", V_OE);
    tick(); check("ab_e1_oe", V_OE);
    tick(); check("ab_e2_rst", V_RST);
    tick(); check("ab_e3_rst", V_RST);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("ab_stop_1", V_STOP);
    tick(); check("ab_stop_2", V_STOP);
    tick(); check("ab_idle", V_IDLE);

    // Start+stop together in SETTLE, with txnrx_req high while settling.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    check("col_e5_rst", V_RST);
    txnrx_req = 1'b1;
    tick(); check("col_e6_settle_tx0", V_SETTLE);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("col_stop_wins", V_STOP);
    tick(); check("col_stop_2", V_STOP);
    tick(); check("col_idle", V_IDLE);
    txnrx_req = 1'b0;

    // Asynchronous reset while in RUN, then a repeat bring-up.
    bring_up("pre");
    txnrx_req = 1'b1;
    tick(); check("pre_run_tx1", v_run(1'b0, 1'b1));
    #1;
    bus_rst = 1'b1;
    #1;
    check("async_rst_in_run", V_IDLE);
    tick(); check("async_rst_held", V_IDLE);
    @(negedge bus_clk);
    bus_rst   = 1'b0;
    txnrx_req = 1'b0;
    tick(); check("after_rst_idle", V_IDLE);
    tick(); check("after_rst_idle_2", V_IDLE);
    bring_up("rep");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cat_pwr_seq.md
CAT_PWR_SEQ -- requirements
Module: cat_pwr_seq

Interface
REQ-001 Parameter T_OE, default 16: cycles to drive the CAT control pins before the reset phase; also the cycles of the STOP phase; SHALL be >= 1.
REQ-002 Parameter T_RST, default 1000: cycles cat_resetn is held low during bring-up; SHALL be >= 1.
REQ-003 Parameter T_SETTLE, default 5000: cycles from cat_resetn release to cat_enable; SHALL be >= 1.
REQ-004 Parameter CNT_W, default 16: width of the phase counter; each T_* value SHALL fit in CNT_W bits.
REQ-005 bus_clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 bus_rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to begin bring-up.
REQ-008 stop  in  1  one-cycle request to power down.
REQ-009 txnrx_req  in  1  requested CAT TXNRX level while running.
REQ-010 cat_oe  out  1  1 = the CAT control pin IOBUFs drive their outputs (T = ~cat_oe).
REQ-011 cat_resetn  out  1  CAT reset, active-low.
REQ-012 cat_enable  out  1  CAT ENABLE.
REQ-013 cat_txnrx  out  1  CAT TXNRX.
REQ-014 ready  out  1  high while in RUN.
REQ-015 busy  out  1  high in OE, RST, SETTLE and STOP.
REQ-016 done  out  1  one-cycle pulse on entry to RUN.
REQ-017 state  out  3  debug encoding: IDLE=0, OE=1, RST=2, SETTLE=3, RUN=4, STOP=5.

Function
REQ-018 All outputs SHALL be registered Moore outputs that reflect the new state in the cycle after the transition edge.
REQ-019 The states SHALL have these outputs:
- IDLE: everything 0.
- OE: cat_oe=1, cat_resetn=0.
- RST: cat_oe=1, cat_resetn=0.
- SETTLE: cat_oe=1, cat_resetn=1.
- RUN: cat_oe=1, cat_resetn=1, cat_enable=1, ready=1.
- STOP: cat_oe=1, cat_resetn=0, cat_enable=0, cat_txnrx=0.
REQ-020 On every state entry the phase counter SHALL load T-1, decrement once per cycle, and leave the state on the edge where it reads 0, so the FSM stays exactly T cycles in OE, RST, SETTLE and STOP.
REQ-021 The timed transitions SHALL be OE -> RST after T_OE, RST -> SETTLE after T_RST, SETTLE -> RUN after T_SETTLE, and STOP -> IDLE after T_OE.
REQ-022 start sampled high in IDLE SHALL move the FSM to OE; start in any other state SHALL be ignored.
REQ-023 stop sampled high in OE, RST, SETTLE or RUN SHALL move the FSM to STOP; stop in IDLE or STOP SHALL be ignored and SHALL NOT restart the STOP counter.
REQ-024 If start and stop are high in the same cycle, stop SHALL win (in IDLE, neither has any effect).
REQ-025 In RUN, cat_txnrx SHALL equal txnrx_req registered once (1-cycle latency); in every other state it SHALL be 0.
REQ-026 done SHALL be high only in the first cycle of RUN.
REQ-027 The phase counter SHALL never wrap; no state other than OE, RST, SETTLE and STOP consumes the counter.

Reset
REQ-028 While bus_rst is high, the FSM SHALL be IDLE, the counter 0 and every output 0, asynchronously.
REQ-029 Assertion of bus_rst mid-sequence, including RUN, SHALL drop cat_enable, cat_resetn and cat_oe immediately, without a STOP phase.
REQ-030 After bus_rst deasserts, the FSM SHALL remain in IDLE until start.

Verification (T_OE=2, T_RST=4, T_SETTLE=3)
REQ-031 Nominal bring-up:
- stimulus: start pulse at edge 0.
- response: cat_oe=1 after edge 0; cat_resetn rises after edge 6; ready=1 and done=1 after edge 9; done=0 after edge 10.
REQ-032 Stop from RUN:
- stimulus: stop pulse with txnrx_req=1.
- response: next cycle cat_enable=0, cat_txnrx=0, cat_resetn=0, busy=1, state=5; two cycles later all outputs are 0 and state=0.
REQ-033 Abort and collisions:
- stop during RST at counter=2 -> state goes to STOP and cat_resetn never rises.
- start and stop together in SETTLE -> state goes to STOP.
- start while in STOP -> ignored.
REQ-034 TX control:
- in RUN, toggle txnrx_req 0,1,1,0 -> cat_txnrx follows 1 cycle later.
- in SETTLE, txnrx_req=1 -> cat_txnrx=0.
REQ-035 Reset handling:
- bus_rst asserted between edges while in RUN -> all outputs 0 before the next edge.
- after release -> state=0; a later start repeats the REQ-031 timing.
REQ-036 Idle inputs: stop in IDLE, and start or stop held high during reset -> no output change and state stays 0.
